rx_mf_slicer: RTL
=================

Name: rx_mf_slicer

Overview:
- Receive-side matched filter and symbol recovery for the 4-ary PAM link, 4 samples/symbol.
- Takes one 1s17 sample per `in_valid`, runs a 21-tap symmetric SRRC FIR with true multipliers, and decimates by SPS at a fixed sampling phase.
- Slices each decimated sample into a 2-bit symbol.
- Sits between the channel/ADC model and symbol-error counting logic.

Parameters:
- SPS, 4, samples per symbol; decimation factor.
- PHASE, 0, decimation phase (0..SPS-1) at which a symbol is taken.
- THR, 43690, slicer outer threshold (1s17, about 1/3).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- in_valid  in  1  `x_in` valid this cycle; sample accepted on this clk edge.
- x_in  in  18  signed input sample, 1s17.
- mf_out  out  18  signed matched-filter output, 1s17, saturated.
- mf_valid  out  1  `mf_out` updated this cycle (1-clk pulse).
- sym_out  out  2  sliced symbol.
- sym_valid  out  1  `sym_out` updated this cycle (1-clk pulse).

Behaviour:
- Clocking and reset (already decided): one clock, `clk`; `reset` is synchronous and active-high.
- Reset effects: clears the delay line, all pipeline registers, the valid pipe, and the phase counter. `mf_out`=0, `mf_valid`=0, `sym_out`=2'b00, `sym_valid`=0. Reset mid-stream discards all in-flight samples, with no spurious valid after release.
- Input and delay line:
  - `x_in` is sign-extended to 2s16: {x_in[17], x_in[17:1]}.
  - Shifts into a 21-entry delay line x[0..20] only on `in_valid`=1; holds otherwise.
- Stage 1 (reg): pre-add p[i]=x[i]+x[20-i] for i=0..9, and p[10]=x[10]. 18-bit, no overflow possible.
- Stage 2 (reg): products m[i]=p[i]*h[i], 36-bit signed.
- Coefficients: h[i] are 0s17 constants in a case ROM. h[0..10] = 134, 2522, 3586, -162, -8622, -15048, -8652, 17192, 57198, 94305, 109441.
- Stage 3 (reg): 40-bit sum of m[0..10].
- Output scaling: shift right arithmetically by 16, then saturate to [-131072, 131071], giving `mf_out`.
- Latency: the sample accepted on edge N gives `mf_out`/`mf_valid` registered on edge N+3.
  - The arithmetic pipe is free-running; a 3-deep valid shift register tracks `in_valid`.
  - Back-to-back or gapped `in_valid` are both legal.
- Decimator:
  - Phase counter 0..SPS-1 increments on each `mf_valid`; it wraps from SPS-1 to 0.
  - When `mf_valid`=1 and counter==PHASE, the slicer registers a symbol one clock later (edge N+4). `sym_valid` pulses exactly once per SPS `mf_valid` pulses.
- Slicer, on y=`mf_out`:
  - y < -THR gives 2'b00.
  - -THR ≤ y < 0 gives 2'b01.
  - 0 ≤ y < THR gives 2'b10.
  - y ≥ THR gives 2'b11.
  - Boundaries: y=0 gives 10; y=THR gives 11; y=-THR gives 01.
- `sym_out` holds its value between `sym_valid` pulses.
- Simultaneous `in_valid` and reset: reset wins and the sample is dropped.

Optional Feature:
- Macro: SLICER_ERR_EN.
- When defined: adds output port `sym_err` (18-bit signed, 1s17), registered with `sym_valid`.
  - sym_err = y − ideal level, with ideal levels -65535, -21845, 21845, 65535 for symbols 00, 01, 10, 11.
  - Computed in 19 bits and saturated to 18.
  - Reset value 0; holds between pulses.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset check: assert reset for 3 clks with `in_valid`=1 and `x_in`=5000 → `mf_out`=0, `mf_valid`=0, `sym_valid`=0 during reset and through the first 3 clks after release.
- Impulse response: one `in_valid` with `x_in`=-131072, then zeros on every clock → `mf_out` sequence starting 3 clks later is -134, -2522, -3586, 162, 8622, 15048, 8652, -17192, -57198, -94305, -109441, then mirrored back to -134, then 0.
- Gapped input: same impulse with `in_valid` high every 3rd clk → identical `mf_out` values; `mf_valid` pulses only 3 clks after each accepted sample.
- Decimation phase: continuous `in_valid`, PHASE=2 → first `sym_valid` one clk after the 3rd `mf_valid`, then every 4th `mf_valid`; over 40 samples exactly 10 `sym_valid` pulses.
- Saturation and slicing: constant `x_in`=65536 (DC) → `mf_out` settles at 131071, `sym_out`=2'b11. Constant `x_in`=-65536 → -131072, 2'b00. Force `mf_out`=0 via all-zero input → 2'b10.
- Reset mid-stream: assert reset 1 clk during a continuous impulse train → valids drop next edge, counter restarts; after release the first `sym_valid` again follows the (PHASE+1)th `mf_valid`. With SLICER_ERR_EN: `mf_out`=131071 → `sym_err`=65536.

Source files
------------

// File: rtl/rx_mf_slicer.sv
// rx_mf_slicer: 21-tap symmetric SRRC matched filter, decimate-by-SPS, 4-level PAM slicer.
// Optional macro SLICER_ERR_EN adds the registered slicer error output sym_err.

module rx_mf_tap #(
  parameter int IDX = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [17:0] a,
  input  logic signed [17:0] b,
  output logic signed [35:0] m
);
  logic signed [17:0] p, h;

  // Half of the symmetric SRRC response, 0s17; IDX 10 is the centre tap.
  always_comb begin
    case (IDX)
      0:       h = 18'sd134;
      1:       h = 18'sd2522;
      2:       h = 18'sd3586;
      3:       h = -18'sd162;
      4:       h = -18'sd8622;
      5:       h = -18'sd15048;
      6:       h = -18'sd8652;
      7:       h = 18'sd17192;
      8:       h = 18'sd57198;
      9:       h = 18'sd94305;
      default: h = 18'sd109441;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
      m <= '0;
    end else begin
      p <= a + b;
      m <= p * h;
    end
  end
endmodule

module rx_mf_slicer #(
  parameter int SPS   = 4,
  parameter int PHASE = 0,
  parameter int THR   = 43690
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [17:0] x_in,
  output logic signed [17:0] mf_out,
  output logic               mf_valid,
  output logic [1:0]         sym_out,
  output logic               sym_valid
`ifdef SLICER_ERR_EN
  ,
  output logic signed [17:0] sym_err
`endif
);
  localparam int NTAP   = 21;
  localparam int NHALF  = 11;
  localparam int STAGES = 3;
  localparam int CW     = (SPS > 1) ? $clog2(SPS) : 1;

  logic [NTAP-1:0][17:0]  x;
  logic [NHALF-1:0][35:0] m;
  logic [STAGES:0]        vld_pipe;
  logic [39:0]            acc;
  logic signed [39:0]     sh;
  logic signed [17:0]     y_sat;
  logic [CW-1:0]          cnt;
  logic [1:0]             sym_nxt;
  logic                   take;

  always_ff @(posedge clk) begin
    if (reset)         x <= '0;
    else if (in_valid) x <= {x[NTAP-2:0], x_in >>> 1};
  end

  for (genvar i = 0; i < NHALF; i++) begin : g_tap
    rx_mf_tap #(.IDX(i)) u_tap (
      .clk   (clk),
      .reset (reset),
      .a     (x[i]),
      .b     ((i == NHALF-1) ? '0 : x[NTAP-1-i]),
      .m     (m[i])
    );
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NHALF; i++) acc = acc + {{4{m[i][35]}}, m[i]};
  end

  // The 40-bit sum is folded into the mf_out register so the sample-to-output latency is 3.
  assign sh = $signed(acc) >>> 16;
  always_comb begin
    if (sh > 40'sd131071)       y_sat = 18'sd131071;
    else if (sh < -40'sd131072) y_sat = -18'sd131072;
    else                        y_sat = sh[17:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      mf_out   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      mf_out   <= y_sat;
    end
  end
  assign mf_valid = vld_pipe[STAGES];

  always_comb begin
    if (mf_out < -THR)    sym_nxt = 2'b00;
    else if (mf_out < 0)  sym_nxt = 2'b01;
    else if (mf_out < THR) sym_nxt = 2'b10;
    else                  sym_nxt = 2'b11;
  end

  assign take = mf_valid && (cnt == CW'(PHASE));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= take;
      if (mf_valid) cnt <= (cnt == CW'(SPS-1)) ? '0 : cnt + CW'(1);
      if (take)     sym_out <= sym_nxt;
    end
  end

`ifdef SLICER_ERR_EN
  logic signed [18:0] ideal, err;
  always_comb begin
    case (sym_nxt)
      2'b00:   ideal = -19'sd65535;
      2'b01:   ideal = -19'sd21845;
      2'b10:   ideal = 19'sd21845;
      default: ideal = 19'sd65535;
    endcase
    err = $signed({mf_out[17], mf_out}) - ideal;
  end

  always_ff @(posedge clk) begin
    if (reset) sym_err <= '0;
    else if (take) begin
      if (err > 19'sd131071)       sym_err <= 18'sd131071;
      else if (err < -19'sd131072) sym_err <= -18'sd131072;
      else                         sym_err <= err[17:0];
    end
  end
`endif
endmodule
